// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port BRAM between fetch and load/store.
// Datapath has priority; a grant streak cap keeps fetch from starving.
module mem_port_arbiter #(
   parameter int ADDR_W        = 10,
   parameter int DATA_W        = 32,
   parameter int READ_LAT      = 1,
   parameter int MAX_DP_STREAK = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_ack,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              dp_req,
   input  logic              dp_we,
   input  logic [ADDR_W-1:0] dp_addr,
   input  logic [DATA_W-1:0] dp_wdata,
   output logic              dp_ack,
   output logic [DATA_W-1:0] dp_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              stall
);

   localparam int SW = $clog2(MAX_DP_STREAK + 2);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t        state;
   state_t        state_nx;
   logic          accept;
   logic          pick_dp;
   logic          gnt_dp;
   logic          gnt_wr;
   logic [1:0]    cnt;
   logic [SW-1:0] streak;

   always_comb begin
      accept   = 1'b0;
      state_nx = state;
      pick_dp  = dp_req & ~(if_req & (streak == SW'(MAX_DP_STREAK)));
      case (state)
         IDLE: begin
            if (if_req | dp_req) begin
               accept   = 1'b1;
               state_nx = ISSUE;
            end
         end
         ISSUE:   state_nx = (READ_LAT == 1) ? RESP : WAIT;
         WAIT:    if (cnt == 2'd0) state_nx = RESP;
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         gnt_dp    <= 1'b0;
         gnt_wr    <= 1'b0;
         cnt       <= '0;
         streak    <= '0;
         if_rdata  <= '0;
         dp_rdata  <= '0;
      end else begin
         mem_en <= accept;
         mem_we <= accept & pick_dp & dp_we;
         if (accept) begin
            gnt_dp   <= pick_dp;
            gnt_wr   <= pick_dp & dp_we;
            mem_addr <= pick_dp ? dp_addr : if_addr;
            if (pick_dp) mem_wdata <= dp_wdata;
            cnt      <= 2'(READ_LAT - 1);
         end else if (cnt != 2'd0) begin
            cnt <= cnt - 2'd1;
         end
         // streak only counts datapath wins over a waiting fetch
         if (state == IDLE) begin
            if (!if_req || (accept && !pick_dp))
               streak <= '0;
            else if (accept && streak != SW'(MAX_DP_STREAK))
               streak <= streak + SW'(1);
         end
         if (state_nx == RESP && !gnt_wr) begin
            if (gnt_dp) dp_rdata <= mem_rdata;
            else        if_rdata <= mem_rdata;
         end
      end
   end

   assign if_ack = (state == RESP) & ~gnt_dp;
   assign dp_ack = (state == RESP) & gnt_dp;
   assign stall  = (if_req & ~if_ack) | (dp_req & ~dp_ack);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_mem_port_arbiter;

   localparam int AW    = 10;
   localparam int DW    = 32;
   localparam int MAXS  = 2;
   localparam int LAT_A = 1;

   logic clk = 1'b0;
   logic reset;

   logic          if_req, if_ack, dp_req, dp_we, dp_ack;
   logic          mem_en, mem_we, stall;
   logic [AW-1:0] if_addr, dp_addr, mem_addr;
   logic [DW-1:0] if_rdata, dp_rdata, dp_wdata, mem_wdata, mem_rdata;

   logic          if_req_b, if_ack_b, dp_req_b, dp_we_b, dp_ack_b;
   logic          mem_en_b, mem_we_b, stall_b;
   logic [AW-1:0] if_addr_b, dp_addr_b, mem_addr_b;
   logic [DW-1:0] if_rdata_b, dp_rdata_b, dp_wdata_b;
   logic [DW-1:0] mem_wdata_b, mem_rdata_b;

   logic [DW-1:0] mem_a [0:1023];
   logic [DW-1:0] mem_b [0:1023];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign mem_rdata   = mem_a[mem_addr];
   assign mem_rdata_b = mem_b[mem_addr_b];

   always @(posedge clk) begin
      if (mem_en && mem_we) mem_a[mem_addr] = mem_wdata;
      if (mem_en_b && mem_we_b) mem_b[mem_addr_b] = mem_wdata_b;
   end

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LAT(LAT_A), .MAX_DP_STREAK(MAXS)
   ) dut_a (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
      .if_rdata(if_rdata),
      .dp_req(dp_req), .dp_we(dp_we), .dp_addr(dp_addr),
      .dp_wdata(dp_wdata), .dp_ack(dp_ack), .dp_rdata(dp_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall)
   );

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .READ_LAT(3), .MAX_DP_STREAK(MAXS)
   ) dut_b (
      .clk(clk), .reset(reset),
      .if_req(if_req_b), .if_addr(if_addr_b), .if_ack(if_ack_b),
      .if_rdata(if_rdata_b),
      .dp_req(dp_req_b), .dp_we(dp_we_b), .dp_addr(dp_addr_b),
      .dp_wdata(dp_wdata_b), .dp_ack(dp_ack_b), .dp_rdata(dp_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
      .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b), .stall(stall_b)
   );

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({if_ack, dp_ack, mem_en, mem_we, stall, mem_addr,
           mem_wdata, if_rdata, dp_rdata} !== '0) begin
         errors++;
         $display("FAIL reset_a: outputs %b %b %b %b %b %h %h %h %h, want all 0",
                  if_ack, dp_ack, mem_en, mem_we, stall, mem_addr,
                  mem_wdata, if_rdata, dp_rdata);
      end
      checks++;
      if ({if_ack_b, dp_ack_b, mem_en_b, mem_we_b, stall_b, mem_addr_b,
           mem_wdata_b, if_rdata_b, dp_rdata_b} !== '0) begin
         errors++;
         $display("FAIL reset_b: some output nonzero, want all 0");
      end
      checks++;
      if (dut_a.streak !== '0) begin
         errors++;
         $display("FAIL reset_streak: got %0d want 0", dut_a.streak);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_read();
      mem_a[4] = 32'hDEADBEEF;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 10'h004;
      #1;
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL read_stall_c0: got %b want 1", stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, stall} !== {1'b1, 1'b0, 10'h004, 1'b1}) begin
         errors++;
         $display("FAIL read_issue: en=%b we=%b addr=%h stall=%b want 1 0 004 1",
                  mem_en, mem_we, mem_addr, stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if_ack, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin
         errors++;
         $display("FAIL read_ack: ack=%b rdata=%h want 1 deadbeef", if_ack, if_rdata);
      end
      checks++;
      if ({stall, mem_en} !== 2'b00) begin
         errors++;
         $display("FAIL read_stall_c2: stall=%b en=%b want 0 0", stall, mem_en);
      end
      @(negedge clk);
      if_req = 1'b0;
   endtask

   task automatic test_tie();
      mem_a[10'h100] = 32'hA5A50100;
      mem_a[10'h008] = 32'h0B0B0008;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 10'h008;
      dp_req  = 1'b1;
      dp_we   = 1'b0;
      dp_addr = 10'h100;
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, 10'h100}) begin
         errors++;
         $display("FAIL tie_first: en=%b addr=%h want 1 100", mem_en, mem_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({dp_ack, if_ack, dp_rdata, stall} !== {2'b10, 32'hA5A50100, 1'b1}) begin
         errors++;
         $display("FAIL tie_dp_ack: dack=%b iack=%b rdata=%h stall=%b",
                  dp_ack, if_ack, dp_rdata, stall);
      end
      @(negedge clk);
      dp_req = 1'b0;
      #1;
      checks++;
      if ({mem_en, stall} !== 2'b01) begin
         errors++;
         $display("FAIL tie_c3: en=%b stall=%b want 0 1", mem_en, stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr} !== {2'b10, 10'h008}) begin
         errors++;
         $display("FAIL tie_fetch_issue: en=%b we=%b addr=%h want 1 0 008",
                  mem_en, mem_we, mem_addr);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if_ack, dp_ack, if_rdata} !== {2'b10, 32'h0B0B0008}) begin
         errors++;
         $display("FAIL tie_if_ack: iack=%b dack=%b rdata=%h want 1 0 0b0b0008",
                  if_ack, dp_ack, if_rdata);
      end
      @(negedge clk);
      if_req = 1'b0;
   endtask

   task automatic test_store();
      @(negedge clk);
      dp_req   = 1'b1;
      dp_we    = 1'b1;
      dp_addr  = 10'h020;
      dp_wdata = 32'h12345678;
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en, mem_we, mem_addr, mem_wdata} !==
          {2'b11, 10'h020, 32'h12345678}) begin
         errors++;
         $display("FAIL store_issue: en=%b we=%b addr=%h wdata=%h",
                  mem_en, mem_we, mem_addr, mem_wdata);
      end
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en, mem_we, dp_ack} !== 3'b001) begin
         errors++;
         $display("FAIL store_ack: en=%b we=%b ack=%b want 0 0 1",
                  mem_en, mem_we, dp_ack);
      end
      checks++;
      if (dp_rdata !== 32'hA5A50100) begin
         errors++;
         $display("FAIL store_rdata_hold: got %h want a5a50100", dp_rdata);
      end
      checks++;
      if (mem_a[10'h020] !== 32'h12345678) begin
         errors++;
         $display("FAIL store_mem: got %h want 12345678", mem_a[10'h020]);
      end
      @(negedge clk);
      dp_req = 1'b0;
      dp_we  = 1'b0;
   endtask

   task automatic test_starvation();
      bit order[$];
      int k = 0;
      int s_after = -1;
      bit p_dack = 1'b0;
      bit p_iack = 1'b0;
      bit got = 1'b0;
      logic [3:0] seq;
      @(negedge clk);
      if_req  = 1'b1;
      if_addr = 10'h040;
      dp_req  = 1'b1;
      dp_we   = 1'b0;
      dp_addr = 10'h200;
      for (int c = 0; c < 30 && order.size() < 4; c++) begin
         if (c > 0) begin
            @(negedge clk);
            if (p_dack) begin
               k++;
               dp_addr = 10'h200 + 10'(k);
            end
            if (p_iack) if_req = 1'b0;
         end
         #1;
         if (mem_en) begin
            order.push_back(mem_addr >= 10'h200);
            if (mem_addr < 10'h200) s_after = int'(dut_a.streak);
         end
         p_dack = dp_ack;
         p_iack = if_ack;
      end
      seq = 4'bxxxx;
      if (order.size() == 4) seq = {order[0], order[1], order[2], order[3]};
      checks++;
      if (seq !== 4'b1101) begin
         errors++;
         $display("FAIL starve_order: got %b want 1101 (1=DP)", seq);
      end
      checks++;
      if (s_after !== 0) begin
         errors++;
         $display("FAIL starve_streak: got %0d want 0", s_after);
      end
      for (int i = 0; i < 10 && !got; i++) begin
         @(negedge clk);
         #1;
         got = dp_ack;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL starve_last_ack: got none want dp_ack");
      end
      @(negedge clk);
      dp_req = 1'b0;
      if_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      bit got = 1'b0;
      @(negedge clk);
      dp_req  = 1'b1;
      dp_we   = 1'b0;
      dp_addr = 10'h100;
      @(negedge clk);
      reset  = 1'b1;
      dp_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++;
      if ({mem_en, mem_we, dp_ack, dp_rdata} !== '0) begin
         errors++;
         $display("FAIL rmid_abort: en=%b we=%b ack=%b rdata=%h want 0",
                  mem_en, mem_we, dp_ack, dp_rdata);
      end
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         #1;
         if (dp_ack) seen = 1'b1;
      end
      checks++;
      if (seen) begin
         errors++;
         $display("FAIL rmid_no_ack: got dp_ack want none");
      end
      @(negedge clk);
      dp_req = 1'b1;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         #1;
         got = dp_ack;
      end
      checks++;
      if ({got, dp_rdata} !== {1'b1, 32'hA5A50100}) begin
         errors++;
         $display("FAIL rmid_fresh: ack=%b rdata=%h want 1 a5a50100",
                  got, dp_rdata);
      end
      @(negedge clk);
      dp_req = 1'b0;
   endtask

   task automatic test_latency();
      bit bad = 1'b0;
      mem_b[10'h3FF] = 32'hC0C003FF;
      mem_b[10'h3FE] = 32'h0D0D03FE;
      @(negedge clk);
      if_req_b  = 1'b1;
      if_addr_b = 10'h3FF;
      @(negedge clk);
      #1;
      checks++;
      if ({mem_en_b, mem_we_b, mem_addr_b} !== {2'b10, 10'h3FF}) begin
         errors++;
         $display("FAIL lat_issue: en=%b we=%b addr=%h want 1 0 3ff",
                  mem_en_b, mem_we_b, mem_addr_b);
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         #1;
         if (mem_en_b || if_ack_b || !stall_b) bad = 1'b1;
      end
      checks++;
      if (bad) begin
         errors++;
         $display("FAIL lat_wait: en/ack high or stall low in cycles 2-3");
      end
      @(negedge clk);
      #1;
      checks++;
      if ({if_ack_b, if_rdata_b, stall_b} !== {1'b1, 32'hC0C003FF, 1'b0}) begin
         errors++;
         $display("FAIL lat_ack: ack=%b rdata=%h stall=%b want 1 c0c003ff 0",
                  if_ack_b, if_rdata_b, stall_b);
      end
      @(negedge clk);
      if_addr_b = 10'h3FE;
      #1;
      checks++;
      if (mem_en_b !== 1'b0) begin
         errors++;
         $display("FAIL lat_c5: en=%b want 0", mem_en_b);
      end
      @(negedge clk);
      if_req_b = 1'b0;
      #1;
      checks++;
      if ({mem_en_b, mem_addr_b} !== {1'b1, 10'h3FE}) begin
         errors++;
         $display("FAIL lat_b2b_issue: en=%b addr=%h want 1 3fe",
                  mem_en_b, mem_addr_b);
      end
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if ({if_ack_b, if_rdata_b, stall_b} !== {1'b1, 32'h0D0D03FE, 1'b0}) begin
         errors++;
         $display("FAIL lat_drop_ack: ack=%b rdata=%h stall=%b want 1 0d0d03fe 0",
                  if_ack_b, if_rdata_b, stall_b);
      end
   endtask

   task automatic test_random();
      int m_free = 0;
      int m_acc  = -10;
      int m_ack  = -10;
      int m_str  = 0;
      bit m_dp = 1'b0;
      bit m_wr = 1'b0;
      bit i_act = 1'b0;
      bit d_act = 1'b0;
      bit e_ia, e_da, e_en, e_st, pick;
      logic [AW-1:0] m_addr = '0;
      logic [DW-1:0] m_rd = '0;
      logic [DW-1:0] ref_mem [0:15];
      for (int i = 0; i < 16; i++) begin
         mem_a[i]   = $urandom;
         ref_mem[i] = mem_a[i];
      end
      @(negedge clk);
      if_req = 1'b0;
      dp_req = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         if (!i_act && $urandom_range(0, 2) == 0) begin
            i_act   = 1'b1;
            if_addr = 10'($urandom_range(0, 15));
         end
         if (!d_act && $urandom_range(0, 1) == 0) begin
            d_act    = 1'b1;
            dp_addr  = 10'($urandom_range(0, 15));
            dp_we    = 1'($urandom_range(0, 1));
            dp_wdata = $urandom;
         end
         if_req = i_act;
         dp_req = d_act;
         #1;
         e_ia = (c == m_ack) && !m_dp;
         e_da = (c == m_ack) && m_dp;
         e_en = (c == m_acc + 1);
         e_st = (i_act && !e_ia) || (d_act && !e_da);
         checks++;
         if ({if_ack, dp_ack, mem_en, stall} !== {e_ia, e_da, e_en, e_st}) begin
            errors++;
            $display("FAIL rnd_ctrl c=%0d: iack/dack/en/stall=%b%b%b%b want %b%b%b%b",
                     c, if_ack, dp_ack, mem_en, stall, e_ia, e_da, e_en, e_st);
         end
         if (e_en) begin
            checks++;
            if ({mem_addr, mem_we} !== {m_addr, m_wr}) begin
               errors++;
               $display("FAIL rnd_issue c=%0d: addr=%h we=%b want %h %b",
                        c, mem_addr, mem_we, m_addr, m_wr);
            end
         end
         if ((e_ia || e_da) && !m_wr) begin
            checks++;
            if ((e_ia ? if_rdata : dp_rdata) !== m_rd) begin
               errors++;
               $display("FAIL rnd_rdata c=%0d: got %h want %h",
                        c, e_ia ? if_rdata : dp_rdata, m_rd);
            end
         end
         if (e_ia) i_act = 1'b0;
         if (e_da) d_act = 1'b0;
         if (c >= m_free) begin
            if (!if_req) m_str = 0;
            if (if_req || dp_req) begin
               pick = dp_req && !(if_req && m_str == MAXS);
               if (!pick) m_str = 0;
               else if (if_req && m_str < MAXS) m_str++;
               m_dp   = pick;
               m_wr   = pick && dp_we;
               m_addr = pick ? dp_addr : if_addr;
               m_acc  = c;
               m_ack  = c + 1 + LAT_A;
               m_free = c + LAT_A + 2;
               if (m_wr) ref_mem[m_addr[3:0]] = dp_wdata;
               else      m_rd = ref_mem[m_addr[3:0]];
            end
         end
      end
      @(negedge clk);
      if_req = 1'b0;
      dp_req = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem_a[i] = 32'hF0000000 + i;
         mem_b[i] = 32'hE0000000 + i;
      end
      reset      = 1'b1;
      if_req     = 1'b0;
      if_addr    = '0;
      dp_req     = 1'b0;
      dp_we      = 1'b0;
      dp_addr    = '0;
      dp_wdata   = '0;
      if_req_b   = 1'b0;
      if_addr_b  = '0;
      dp_req_b   = 1'b0;
      dp_we_b    = 1'b0;
      dp_addr_b  = '0;
      dp_wdata_b = '0;
      test_reset();
      test_read();
      test_tie();
      test_store();
      test_starvation();
      test_reset_mid();
      test_latency();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
